// File: rtl/sram64x64_ctrl.sv
// ============================================================================
// Module  : sram64x64_ctrl
// Brief   : 64x64 logical memory over a 128x32 dual-port SRAM macro, with
//           clear sequence and two-requester round-robin arbitration.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sram64x64_ctrl #(
   parameter bit          INIT_ON_RESET = 1'b1,
   parameter logic [63:0] INIT_VALUE    = 64'h0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             init_req_i,
   output logic             busy_o,
   input  logic [1:0]       req_valid_i,
   output logic [1:0]       req_ready_o,
   input  logic [1:0]       req_we_i,
   input  logic [1:0][5:0]  req_addr_i,
   input  logic [1:0][63:0] req_wdata_i,
   input  logic [1:0][7:0]  req_be_i,
   output logic [1:0]       rsp_valid_o,
   output logic [63:0]      rsp_rdata_o,
   output logic [6:0]       sram_adra_o,
   output logic [6:0]       sram_adrb_o,
   output logic [31:0]      sram_da_o,
   output logic [31:0]      sram_db_o,
   output logic [31:0]      sram_wema_o,
   output logic [31:0]      sram_wemb_o,
   output logic             sram_wea_o,
   output logic             sram_web_o,
   output logic             sram_mea_o,
   output logic             sram_meb_o,
   input  logic [31:0]      sram_qa_i,
   input  logic [31:0]      sram_qb_i
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [5:0]  cnt;
   logic        ptr;
   logic        rsp_pend;
   logic        rsp_id;
   logic [1:0]  grant;
   logic        gnt_any;
   logic        gnt_id;
   logic [5:0]  sel_addr;
   logic        sel_we;

   // Arbitration: a lone requester wins; under contention the pointer decides.
   always_comb begin
      grant = 2'b00;
      if (state == ST_RUN) begin
         if (req_valid_i == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
         end else begin
            grant = req_valid_i;
         end
      end
   end

   assign gnt_any     = |grant;
   assign gnt_id      = grant[1];
   assign sel_addr    = req_addr_i[gnt_id];
   assign sel_we      = req_we_i[gnt_id];
   assign req_ready_o = grant;

   always_comb begin
      state_nxt   = state;
      sram_adra_o = 7'd0;
      sram_adrb_o = 7'd0;
      sram_da_o   = 32'd0;
      sram_db_o   = 32'd0;
      sram_wema_o = 32'd0;
      sram_wemb_o = 32'd0;
      sram_wea_o  = 1'b0;
      sram_web_o  = 1'b0;
      sram_mea_o  = 1'b0;
      sram_meb_o  = 1'b0;
      case (state)
         ST_INIT: begin
            if (cnt == 6'd63) begin
               state_nxt = ST_RUN;
            end
            sram_mea_o  = 1'b1;
            sram_meb_o  = 1'b1;
            sram_wea_o  = 1'b1;
            sram_web_o  = 1'b1;
            sram_adra_o = {1'b0, cnt};
            sram_adrb_o = {1'b1, cnt};
            sram_da_o   = INIT_VALUE[31:0];
            sram_db_o   = INIT_VALUE[63:32];
            sram_wema_o = 32'hFFFF_FFFF;
            sram_wemb_o = 32'hFFFF_FFFF;
         end
         default: begin
            if (init_req_i) begin
               state_nxt = ST_INIT;
            end
            if (gnt_any) begin
               sram_mea_o  = 1'b1;
               sram_meb_o  = 1'b1;
               sram_adra_o = {1'b0, sel_addr};
               sram_adrb_o = {1'b1, sel_addr};
               if (sel_we) begin
                  sram_wea_o = 1'b1;
                  sram_web_o = 1'b1;
                  sram_da_o  = req_wdata_i[gnt_id][31:0];
                  sram_db_o  = req_wdata_i[gnt_id][63:32];
                  for (int k = 0; k < 4; k++) begin
                     sram_wema_o[8*k +: 8] = {8{req_be_i[gnt_id][k]}};
                     sram_wemb_o[8*k +: 8] = {8{req_be_i[gnt_id][k+4]}};
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         cnt      <= 6'd0;
         ptr      <= 1'b0;
         rsp_pend <= 1'b0;
         rsp_id   <= 1'b0;
      end else begin
         state <= state_nxt;
         // Counter wraps 63->0 on exit, so it is already 0 for the next clear.
         if (state == ST_INIT) begin
            cnt <= cnt + 6'd1;
         end else if (init_req_i) begin
            cnt <= 6'd0;
         end
         if (gnt_any) begin
            ptr <= ~gnt_id;
         end
         rsp_pend <= gnt_any & ~sel_we;
         rsp_id   <= gnt_id;
      end
   end

   assign rsp_valid_o = rsp_pend ? (rsp_id ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata_o = {sram_qb_i, sram_qa_i};
   assign busy_o      = (state == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_sram64x64_ctrl.sv
// ============================================================================
// Module  : tb_sram64x64_ctrl
// Brief   : Randomized and directed bench with a logical-memory reference model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sram64x64_ctrl;

   localparam logic [63:0] IV = 64'h0;

   logic             clk = 1'b0;
   logic             rst;
   logic             init_req;
   logic             busy;
   logic [1:0]       valid;
   logic [1:0]       ready;
   logic [1:0]       we;
   logic [1:0][5:0]  addr;
   logic [1:0][63:0] wdata;
   logic [1:0][7:0]  be;
   logic [1:0]       rsp_valid;
   logic [63:0]      rdata;
   logic [6:0]       adra, adrb;
   logic [31:0]      da, db, wema, wemb, qa, qb;
   logic             wea, web, mea, meb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram64x64_ctrl #(.INIT_ON_RESET(1'b1), .INIT_VALUE(IV)) dut (
      .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .busy_o(busy),
      .req_valid_i(valid), .req_ready_o(ready), .req_we_i(we),
      .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rdata),
      .sram_adra_o(adra), .sram_adrb_o(adrb), .sram_da_o(da), .sram_db_o(db),
      .sram_wema_o(wema), .sram_wemb_o(wemb), .sram_wea_o(wea), .sram_web_o(web),
      .sram_mea_o(mea), .sram_meb_o(meb), .sram_qa_i(qa), .sram_qb_i(qb)
   );

   // Macro model: synchronous read, bit-masked synchronous write.
   logic [31:0] macro_mem [128];
   initial begin
      for (int i = 0; i < 128; i++) macro_mem[i] = $urandom;
      qa = 32'd0;
      qb = 32'd0;
   end
   always @(posedge clk) begin
      if (mea) begin
         if (wea) macro_mem[adra] <= (macro_mem[adra] & ~wema) | (da & wema);
         else     qa <= macro_mem[adra];
      end
      if (meb) begin
         if (web) macro_mem[adrb] <= (macro_mem[adrb] & ~wemb) | (db & wemb);
         else     qb <= macro_mem[adrb];
      end
   end

   task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] expand(input logic [3:0] b);
      logic [31:0] m;
      for (int k = 0; k < 4; k++) m[8*k +: 8] = b[k] ? 8'hFF : 8'h00;
      return m;
   endfunction

   // Reference model: logical 64x64 memory, remaining clear cycles, pointer, pending response.
   logic [63:0] m_mem [64];
   int          m_left = 64;
   logic        m_ptr = 1'b0;
   logic        m_pend = 1'b0;
   logic        m_pid = 1'b0;
   logic [63:0] m_pdata = 64'd0;

   always @(negedge clk) begin
      logic [1:0]   eready;
      logic [145:0] got, exp, care;
      logic         id;
      int           idx;
      if (rst) begin
         m_left = 64; m_ptr = 1'b0; m_pend = 1'b0;
         chk("rst_ready", ready, 2'b00);
         chk("rst_rspv", rsp_valid, 2'b00);
         chk("rst_busy", busy, 1'b1);
      end else begin
         if (m_left > 0)          eready = 2'b00;
         else if (valid == 2'b11) eready = m_ptr ? 2'b10 : 2'b01;
         else                     eready = valid;
         chk("ready", ready, eready);
         chk("busy", busy, m_left > 0);
         chk("rsp_valid", rsp_valid, m_pend ? (m_pid ? 2'b10 : 2'b01) : 2'b00);
         if (m_pend) chk("rdata", rdata, m_pdata);

         got  = {adra, adrb, da, db, wema, wemb, wea, web, mea, meb};
         care = '1;
         exp  = '0;
         if (m_left > 0) begin
            idx = 64 - m_left;
            exp = {1'b0, 6'(idx), 1'b1, 6'(idx), IV[31:0], IV[63:32],
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111};
         end else if (eready != 2'b00) begin
            id = eready[1];
            if (we[id]) begin
               exp = {1'b0, addr[id], 1'b1, addr[id], wdata[id][31:0], wdata[id][63:32],
                      expand(be[id][3:0]), expand(be[id][7:4]), 4'b1111};
            end else begin
               exp  = {1'b0, addr[id], 1'b1, addr[id], 128'd0, 4'b0011};
               care = {14'h3FFF, 128'd0, 4'hF};
            end
         end
         chk("macro_pins", got & care, exp & care);

         m_pend = 1'b0;
         if (m_left > 0) begin
            m_mem[64 - m_left] = IV;
            m_left--;
         end else begin
            if (eready != 2'b00) begin
               id = eready[1];
               if (we[id]) begin
                  for (int k = 0; k < 8; k++)
                     if (be[id][k]) m_mem[addr[id]][8*k +: 8] = wdata[id][8*k +: 8];
               end else begin
                  m_pend  = 1'b1;
                  m_pid   = id;
                  m_pdata = m_mem[addr[id]];
               end
               m_ptr = ~id;
            end
            if (init_req) m_left = 64;
         end
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      valid = 2'b00; we = 2'b00; init_req = 1'b0;
   endtask

   task automatic issue(input int ch, input bit w, input logic [5:0] a,
                        input logic [63:0] d, input logic [7:0] b);
      valid = 2'b00; valid[ch] = 1'b1;
      we[ch] = w; addr[ch] = a; wdata[ch] = d; be[ch] = b;
   endtask

   task automatic wait_init(input string name);
      int n = 0;
      while (busy && n < 100) begin
         go();
         n++;
      end
      chk(name, n, 64);
   endtask

   task automatic read_lit(input string name, input int ch, input logic [5:0] a,
                           input logic [63:0] e);
      issue(ch, 1'b0, a, 64'd0, 8'h00);
      go();
      idle_in();
      chk(name, {rsp_valid, rdata}, {(ch == 1) ? 2'b10 : 2'b01, e});
   endtask

   initial begin
      rst = 1'b1; idle_in(); addr = '0; wdata = '0; be = '0;
      repeat (2) go();
      rst = 1'b0;
      wait_init("init_len_reset");
      read_lit("rd0_clear", 0, 6'd0, 64'h0);
      read_lit("rd31_clear", 0, 6'd31, 64'h0);
      read_lit("rd63_clear", 1, 6'd63, 64'h0);

      issue(0, 1'b1, 6'd5, 64'hDEADBEEF_01234567, 8'hFF);
      go();
      issue(1, 1'b0, 6'd5, 64'd0, 8'h00);
      go();
      idle_in();
      chk("raw_e5", {rsp_valid, rdata}, {2'b10, 64'hDEADBEEF_01234567});

      issue(0, 1'b1, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      #1 chk("wr9_addr", {adra, adrb}, {7'h09, 7'h49});
      go();
      issue(0, 1'b0, 6'd9, 64'd0, 8'h00);
      #1 chk("rd9_addr", {adra, adrb}, {7'h09, 7'h49});
      go();
      idle_in();
      chk("rd9_data", rdata, 64'h00000000_FFFFFFFF);

      rst = 1'b1;
      go();
      rst = 1'b0;
      wait_init("init_len_rr");
      valid = 2'b11; we = 2'b00; addr[0] = 6'd1; addr[1] = 6'd2;
      for (int i = 0; i < 6; i++) begin
         #1 chk("rr_grant", ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         go();
      end
      idle_in();
      go();

      issue(0, 1'b1, 6'd3, 64'h1111_2222_3333_4444, 8'hFF);
      go();
      issue(0, 1'b0, 6'd3, 64'd0, 8'h00);
      init_req = 1'b1;
      go();
      idle_in();
      chk("rd_during_init", {rsp_valid, busy, rdata}, {2'b01, 1'b1, 64'h1111_2222_3333_4444});
      wait_init("init_len_req");
      read_lit("rd3_cleared", 0, 6'd3, IV);

      issue(1, 1'b0, 6'd7, 64'd0, 8'h00);
      go();
      rst = 1'b1;
      idle_in();
      #1 chk("rst_abort", {ready, rsp_valid, busy}, {2'b00, 2'b00, 1'b1});
      go();
      rst = 1'b0;
      wait_init("init_len_abort");

      for (int c = 0; c < 1500; c++) begin
         valid    = 2'($urandom);
         we       = 2'($urandom);
         addr[0]  = 6'($urandom_range(0, 15));
         addr[1]  = 6'($urandom_range(0, 15));
         wdata[0] = {$urandom, $urandom};
         wdata[1] = {$urandom, $urandom};
         be[0]    = 8'($urandom);
         be[1]    = 8'($urandom);
         init_req = ($urandom_range(0, 299) == 0);
         rst      = ($urandom_range(0, 599) == 0);
         go();
      end
      rst = 1'b0;
      idle_in();
      repeat (2) go();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
